exe_dmem_req: RTL and testbench

//  Data-memory request issuer in EXE, directly upstream of MEM. Turns a load/store into an SRAM-like

---
 rtl/exe_dmem_req_pkg.sv | 83 ++++++++
 rtl/exe_dmem_req_if.sv | 28 ++
 rtl/exe_dmem_req_tag_fifo.sv | 71 +++++++
 rtl/exe_dmem_req.sv | 140 ++++++++++++++
 tb/tb_exe_dmem_req.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_dmem_req_pkg.sv
// ---------------------------------------------------------------------------
// exe_dmem_req_pkg
//   Shared definitions for the EXE-stage data-memory request issuer:
//   memop_type one-hot bit positions, SRAM size codes, the issuer FSM state
//   type, the latched request-field bundle, and the helper that turns a
//   load/store into size/addr/wstrb/wdata.
// ---------------------------------------------------------------------------
package exe_dmem_req_pkg;

    // Bit positions inside memop_type = {right,left,uhalf,half,ubyte,byte,word}
    localparam int MEMOP_W     = 7;
    localparam int MEMOP_WORD  = 0;
    localparam int MEMOP_BYTE  = 1;
    localparam int MEMOP_UBYTE = 2;
    localparam int MEMOP_HALF  = 3;
    localparam int MEMOP_UHALF = 4;
    localparam int MEMOP_LEFT  = 5;
    localparam int MEMOP_RIGHT = 6;

    // data_sram_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing requested for the instruction in EXE
        ST_REQ  = 2'd1,   // req asserted, waiting for addr_ok
        ST_ACPT = 2'd2    // accepted by the bus, waiting for EXE->MEM transfer
    } dreq_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dreq_fields_t;

    // Builds the bus view of a load/store. lwl/lwr/swl/swr always access the
    // aligned word; the unaligned part is expressed through wstrb/wdata.
    function automatic dreq_fields_t build_req(
        input logic               we,
        input logic [MEMOP_W-1:0] memop,
        input logic [31:0]        vaddr,
        input logic [31:0]        st
    );
        dreq_fields_t f;
        logic [1:0]   a;
        a       = vaddr[1:0];
        f.wr    = we;
        f.size  = SIZE_WORD;
        f.addr  = vaddr;
        f.wstrb = 4'b1111;
        f.wdata = st;
        if (memop[MEMOP_BYTE] | memop[MEMOP_UBYTE]) begin
            f.size  = SIZE_BYTE;
            f.wstrb = 4'b0001 << a;
            f.wdata = {4{st[7:0]}};
        end else if (memop[MEMOP_HALF] | memop[MEMOP_UHALF]) begin
            f.size  = SIZE_HALF;
            f.wstrb = 4'b0011 << a;
            f.wdata = {2{st[15:0]}};
        end else if (memop[MEMOP_LEFT]) begin
            f.addr = {vaddr[31:2], 2'b00};
            case (a)
                2'd0:    f.wstrb = 4'b0001;
                2'd1:    f.wstrb = 4'b0011;
                2'd2:    f.wstrb = 4'b0111;
                default: f.wstrb = 4'b1111;
            endcase
            f.wdata = st >> {2'd3 - a, 3'b000};
        end else if (memop[MEMOP_RIGHT]) begin
            f.addr  = {vaddr[31:2], 2'b00};
            f.wstrb = 4'b1111 << a;
            f.wdata = st << {a, 3'b000};
        end
        if (!we) begin
            f.wstrb = 4'b0000;
        end
        return f;
    endfunction

endpackage

// File: rtl/exe_dmem_req_if.sv
// ---------------------------------------------------------------------------
// exe_dmem_req_if
//   SRAM-like data-memory request/response bundle.
//   master (issuer): drives req, wr, size, addr, wstrb, wdata;
//                    receives addr_ok (request accepted) and data_ok
//                    (oldest outstanding request answered).
//   slave  (bridge): the mirror image.
// ---------------------------------------------------------------------------
interface exe_dmem_req_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok
    );
endinterface

// File: rtl/exe_dmem_req_tag_fifo.sv
// ---------------------------------------------------------------------------
// exe_dmem_req_tag_fifo
//   In-order record of accepted-but-unanswered data requests. Each entry is a
//   single cancel bit saying whether the owning instruction was killed.
//   clk, reset        clock, synchronous active-high reset
//   push_i            request accepted (req & addr_ok)
//   push_cancel_i     cancel bit for the entry being pushed
//   pop_i             response returned (data_ok); ignored when empty
//   flush_all_i       kill every entry currently held
//   head_cancel_o     cancel bit of the oldest entry
//   count_o           number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module exe_dmem_req_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   push_cancel_i,
    input  logic                   pop_i,
    input  logic                   flush_all_i,
    output logic                   head_cancel_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] cancel_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign pop_ok = pop_i & (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the tag array is only DEPTH flops, so it is reset with
            // everything else; head_cancel_o is then never unknown.
            cancel_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Marking empty slots too is harmless: a push rewrites its slot.
            if (flush_all_i) begin
                cancel_q <= '1;
            end
            if (push_i) begin
                cancel_q[wr_ptr_q] <= push_cancel_i;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_cancel_o = cancel_q[rd_ptr_q];
    assign count_o       = count_q;

endmodule

// File: rtl/exe_dmem_req.sv
// ---------------------------------------------------------------------------
// exe_dmem_req
//   EXE-stage data-memory request issuer. Turns a load/store into an SRAM-like
//   request, flags AdEL/AdES, gates EXE ready_go, and filters responses so
//   MEM only sees data_ok for requests whose instruction is still alive.
//   clk, reset          clock, synchronous active-high reset
//   es_valid            EXE holds a valid instruction
//   ms_allowin          MEM accepts this cycle
//   flush               WB exception/eret, kills EXE and MEM
//   mem_re / mem_we     load / store
//   memop_type          one-hot {right,left,uhalf,half,ubyte,byte,word}
//   exc_in              instruction already carries an older exception
//   vaddr, st_data      effective address, store data (rt)
//   dmem                request bus (master side)
//   ms_data_ok          data_ok of a live request, to MEM
//   es_mem_ready_go     memory contribution to EXE ready_go
//   es_ade_l/es_ade_s   address error on load/store (combinational)
//   es_badvaddr         vaddr when an address error is flagged, else 0
// ---------------------------------------------------------------------------
module exe_dmem_req
    import exe_dmem_req_pkg::*;
#(
    parameter int OUTS_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                es_valid,
    input  logic                ms_allowin,
    input  logic                flush,
    input  logic                mem_re,
    input  logic                mem_we,
    input  logic [MEMOP_W-1:0]  memop_type,
    input  logic                exc_in,
    input  logic [31:0]         vaddr,
    input  logic [31:0]         st_data,
    exe_dmem_req_if.master      dmem,
    output logic                ms_data_ok,
    output logic                es_mem_ready_go,
    output logic                es_ade_l,
    output logic                es_ade_s,
    output logic [31:0]         es_badvaddr
);
    localparam int CNT_W = $clog2(OUTS_DEPTH) + 1;

    dreq_state_e      state_q, state_d;
    logic             killed_q;
    dreq_fields_t     fields_q, fields_d;
    logic [CNT_W-1:0] outs_count;
    logic             head_cancel;
    logic             mem_op, misalign, ade;
    logic             issue, accept;
    logic             push, push_cancel;

    // ---------------- address error detection ----------------
    assign mem_op   = mem_re | mem_we;
    assign misalign = (memop_type[MEMOP_WORD] & (vaddr[1:0] != 2'b00))
                    | ((memop_type[MEMOP_HALF] | memop_type[MEMOP_UHALF]) & vaddr[0]);
    assign es_ade_l    = mem_re & misalign;
    assign es_ade_s    = mem_we & misalign;
    assign ade         = es_ade_l | es_ade_s;
    assign es_badvaddr = ade ? vaddr : 32'h0;

    assign issue  = es_valid & mem_op & ~exc_in & ~ade & ~flush
                  & (outs_count < CNT_W'(OUTS_DEPTH)) & (state_q == ST_IDLE);
    assign accept = (state_q == ST_REQ) & dmem.addr_ok;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            killed_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            // A flush cannot retract a pending request; remember it so the
            // entry is tagged dead once the bus accepts it.
            killed_q <= (state_q == ST_REQ) & (killed_q | flush);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (issue) state_d = ST_REQ;
            ST_REQ: begin
                if (dmem.addr_ok) begin
                    state_d = (killed_q | flush | ms_allowin) ? ST_IDLE : ST_ACPT;
                end
            end
            ST_ACPT: if (ms_allowin | flush) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dmem.req        = (state_q == ST_REQ);
        push            = accept;
        push_cancel     = killed_q | flush;
        es_mem_ready_go = ~mem_op | exc_in | ade | (state_q == ST_ACPT) | accept;
    end

    // ---------------- request fields ----------------
    // Captured on issue and held untouched while req is up.
    assign fields_d = issue ? build_req(mem_we, memop_type, vaddr, st_data) : fields_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_d;
        end
    end

    assign dmem.wr    = fields_q.wr;
    assign dmem.size  = fields_q.size;
    assign dmem.addr  = fields_q.addr;
    assign dmem.wstrb = fields_q.wstrb;
    assign dmem.wdata = fields_q.wdata;

    // ---------------- outstanding tags ----------------
    exe_dmem_req_tag_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_tag_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (push),
        .push_cancel_i (push_cancel),
        .pop_i         (dmem.data_ok),
        .flush_all_i   (flush),
        .head_cancel_o (head_cancel),
        .count_o       (outs_count)
    );

    assign ms_data_ok = dmem.data_ok & (outs_count != '0) & ~head_cancel;

endmodule

// File: tb/tb_exe_dmem_req.sv
// ---------------------------------------------------------------------------
// tb_exe_dmem_req
//   Self-checking bench for exe_dmem_req: directed scenarios followed by
//   randomized loads/stores. Expected bus fields come from arithmetic models
//   of the encoding rules; expected ms_data_ok comes from a queue of
//   outstanding requests holding an alive/killed flag per entry.
// ---------------------------------------------------------------------------
module tb_exe_dmem_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_valid, ms_allowin, flush, mem_re, mem_we, exc_in;
    logic [6:0]  memop_type;
    logic [31:0] vaddr, st_data;
    logic        ms_data_ok, es_mem_ready_go, es_ade_l, es_ade_s;
    logic [31:0] es_badvaddr;

    exe_dmem_req_if dbus ();

    exe_dmem_req #(.OUTS_DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .es_valid        (es_valid),
        .ms_allowin      (ms_allowin),
        .flush           (flush),
        .mem_re          (mem_re),
        .mem_we          (mem_we),
        .memop_type      (memop_type),
        .exc_in          (exc_in),
        .vaddr           (vaddr),
        .st_data         (st_data),
        .dmem            (dbus),
        .ms_data_ok      (ms_data_ok),
        .es_mem_ready_go (es_mem_ready_go),
        .es_ade_l        (es_ade_l),
        .es_ade_s        (es_ade_s),
        .es_badvaddr     (es_badvaddr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit q[$];   // outstanding requests, oldest first; 1 = killed

    // op index: 0 word,1 byte,2 ubyte,3 half,4 uhalf,5 left,6 right
    function automatic logic [1:0] m_size(input int idx);
        if (idx == 1 || idx == 2) return 2'd0;
        if (idx == 3 || idx == 4) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] m_addr(input int idx, input logic [31:0] va);
        if (idx >= 5) return va - (va % 4);
        return va;
    endfunction

    function automatic logic [3:0] m_wstrb(input int idx, input bit we, input logic [31:0] va);
        int a;
        a = int'(va % 4);
        if (!we) return 4'h0;
        case (idx)
            1, 2:    return 4'(1 << a);
            3, 4:    return 4'(3 << a);
            5:       return 4'((1 << (a + 1)) - 1);
            6:       return 4'(15 << a);
            default: return 4'hf;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input int idx, input logic [31:0] va, input logic [31:0] st);
        int a;
        a = int'(va % 4);
        case (idx)
            1, 2:    return (st & 32'hff) * 32'h0101_0101;
            3, 4:    return (st & 32'hffff) * 32'h0001_0001;
            5:       return st >> (8 * (3 - a));
            6:       return st << (8 * a);
            default: return st;
        endcase
    endfunction

    function automatic bit m_misalign(input int idx, input logic [31:0] va);
        if (idx == 0) return (va % 4) != 0;
        if (idx == 3 || idx == 4) return (va % 2) != 0;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input int idx, input bit we, input logic [31:0] va, input logic [31:0] st);
        es_valid   = 1'b1;
        mem_re     = !we;
        mem_we     = we;
        memop_type = 7'(1 << idx);
        vaddr      = va;
        st_data    = st;
        exc_in     = 1'b0;
    endtask

    task automatic clear_op();
        es_valid   = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        memop_type = 7'h0;
        exc_in     = 1'b0;
    endtask

    // One data_ok pulse; the head of the queue decides whether MEM sees it.
    task automatic respond(input string tag);
        bit exp;
        dbus.data_ok = 1'b1;
        settle();
        exp = (q.size() != 0) ? !q[0] : 1'b0;
        chk({tag, "/ms_data_ok"}, ms_data_ok, exp);
        tick();
        if (q.size() != 0) void'(q.pop_front());
        dbus.data_ok = 1'b0;
    endtask

    // Full life of one request: issue, optional addr_ok delay, acceptance,
    // optional ACPT wait, then EXE empties.
    task automatic issue(input string tag, input int idx, input bit we,
                         input logic [31:0] va, input logic [31:0] st,
                         input int delay, input bit allowin, input int max_wait,
                         input bit dok_at_ok, input bit flush_in_req, input bit flush_at_ok);
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        bit          killed;
        bit          exp_ms;
        int          n;
        e_addr  = m_addr(idx, va);
        e_wstrb = m_wstrb(idx, we, va);
        e_wdata = m_wdata(idx, va, st);
        killed  = 1'b0;

        set_op(idx, we, va, st);
        settle();
        chk({tag, "/req_pre"}, dbus.req, 1'b0);
        chk({tag, "/rg_pre"}, es_mem_ready_go, 1'b0);
        chk({tag, "/badvaddr"}, es_badvaddr, 32'h0);

        n = 0;
        while (!dbus.req && n < max_wait) begin
            tick();
            n++;
        end
        chk({tag, "/req"}, dbus.req, 1'b1);
        chk({tag, "/wr"}, dbus.wr, we);
        chk({tag, "/size"}, dbus.size, m_size(idx));
        chk({tag, "/addr"}, dbus.addr, e_addr);
        chk({tag, "/wstrb"}, dbus.wstrb, e_wstrb);
        if (we) chk({tag, "/wdata"}, dbus.wdata, e_wdata);

        for (int d = 0; d < delay; d++) begin
            if (flush_in_req && d == 0) begin
                flush    = 1'b1;
                es_valid = 1'b0;
            end else begin
                settle();
                chk({tag, "/rg_hold"}, es_mem_ready_go, 1'b0);
            end
            tick();
            if (flush) begin
                foreach (q[i]) q[i] = 1'b1;
                killed = 1'b1;
                flush  = 1'b0;
            end
            chk({tag, "/req_hold"}, dbus.req, 1'b1);
            chk({tag, "/addr_hold"}, dbus.addr, e_addr);
            chk({tag, "/wstrb_hold"}, dbus.wstrb, e_wstrb);
        end

        dbus.addr_ok = 1'b1;
        ms_allowin   = allowin;
        flush        = flush_at_ok;
        dbus.data_ok = dok_at_ok;
        settle();
        if (dok_at_ok) begin
            exp_ms = (q.size() != 0) ? !q[0] : 1'b0;
            chk({tag, "/ms_data_ok_at_ok"}, ms_data_ok, exp_ms);
        end
        chk({tag, "/rg_ok"}, es_mem_ready_go, 1'b1);
        tick();
        if (dok_at_ok && q.size() != 0) void'(q.pop_front());
        if (flush_at_ok) foreach (q[i]) q[i] = 1'b1;
        q.push_back(killed | flush_at_ok);
        dbus.addr_ok = 1'b0;
        dbus.data_ok = 1'b0;
        flush        = 1'b0;
        chk({tag, "/req_post"}, dbus.req, 1'b0);

        if (!killed && !flush_at_ok && !allowin) begin
            chk({tag, "/rg_acpt"}, es_mem_ready_go, 1'b1);
            ms_allowin = 1'b1;
            tick();
        end
        clear_op();
        ms_allowin = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          idx;
        bit          we, aw, dok, fin, fat;
        int          dly;
        logic [31:0] va, st;

        reset        = 1'b1;
        ms_allowin   = 1'b0;
        flush        = 1'b0;
        vaddr        = 32'h0;
        st_data      = 32'h0;
        dbus.addr_ok = 1'b0;
        dbus.data_ok = 1'b0;
        clear_op();
        repeat (2) tick();

        // Reset state, with a stray data_ok on an empty tag FIFO
        dbus.data_ok = 1'b1;
        settle();
        chk("rst/req", dbus.req, 1'b0);
        chk("rst/wr", dbus.wr, 1'b0);
        chk("rst/size", dbus.size, 2'd0);
        chk("rst/addr", dbus.addr, 32'h0);
        chk("rst/wstrb", dbus.wstrb, 4'h0);
        chk("rst/wdata", dbus.wdata, 32'h0);
        chk("rst/ms_data_ok", ms_data_ok, 1'b0);
        chk("rst/rg_no_memop", es_mem_ready_go, 1'b1);
        tick();
        reset        = 1'b0;
        dbus.data_ok = 1'b0;
        tick();

        // lw with addr_ok two cycles late
        issue("lw_late", 0, 1'b0, 32'h100, 32'h0, 2, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        respond("lw_late_rsp");

        // store encodings
        issue("sb", 1, 1'b1, 32'h203, 32'h1234_5678, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        respond("sb_rsp");
        issue("swl", 5, 1'b1, 32'h201, 32'h1234_5678, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        respond("swl_rsp");
        issue("swr", 6, 1'b1, 32'h202, 32'h1234_5678, 1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        respond("swr_rsp");
        issue("sh_acpt", 3, 1'b1, 32'h2a6, 32'hcafe_beef, 1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        respond("sh_acpt_rsp");

        // Address errors and older exception: never issue
        set_op(3, 1'b0, 32'h101, 32'h0);
        settle();
        chk("lh_ade/ade_l", es_ade_l, 1'b1);
        chk("lh_ade/ade_s", es_ade_s, 1'b0);
        chk("lh_ade/badvaddr", es_badvaddr, 32'h101);
        chk("lh_ade/rg", es_mem_ready_go, 1'b1);
        tick();
        chk("lh_ade/no_req", dbus.req, 1'b0);
        set_op(0, 1'b1, 32'h102, 32'h0);
        settle();
        chk("sw_ade/ade_s", es_ade_s, 1'b1);
        chk("sw_ade/ade_l", es_ade_l, 1'b0);
        tick();
        chk("sw_ade/no_req", dbus.req, 1'b0);
        set_op(0, 1'b0, 32'h100, 32'h0);
        exc_in = 1'b1;
        settle();
        chk("exc_in/rg", es_mem_ready_go, 1'b1);
        chk("exc_in/ade_l", es_ade_l, 1'b0);
        tick();
        chk("exc_in/no_req", dbus.req, 1'b0);
        tick();
        chk("exc_in/no_req2", dbus.req, 1'b0);
        clear_op();

        // Two outstanding loads fill the tag FIFO; a third stalls until data_ok
        issue("ld_a", 0, 1'b0, 32'h300, 32'h0, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        issue("ld_b", 4, 1'b0, 32'h306, 32'h0, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        set_op(1, 1'b0, 32'h309, 32'h0);
        settle();
        chk("full/rg", es_mem_ready_go, 1'b0);
        tick();
        chk("full/no_req", dbus.req, 1'b0);
        tick();
        chk("full/no_req2", dbus.req, 1'b0);
        respond("full/rsp_a");
        issue("ld_c", 1, 1'b0, 32'h309, 32'h0, 0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        respond("rsp_b");
        respond("rsp_c");

        // Flush while waiting for addr_ok: request still completes, tagged dead
        issue("ld_kill", 0, 1'b0, 32'h400, 32'h0, 3, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        issue("ld_live", 0, 1'b0, 32'h404, 32'h0, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        respond("rsp_kill");
        respond("rsp_live");
        respond("rsp_empty");

        // addr_ok and data_ok in the same cycle with one outstanding
        issue("ld_m", 0, 1'b0, 32'h500, 32'h0, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        issue("ld_n", 0, 1'b0, 32'h504, 32'h0, 1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        respond("rsp_n");
        respond("rsp_after_n");

        // flush + addr_ok + data_ok in the same cycle
        issue("ld_p", 0, 1'b0, 32'h600, 32'h0, 0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        issue("ld_q", 2, 1'b0, 32'h603, 32'h0, 0, 1'b1, 1, 1'b1, 1'b0, 1'b1);
        respond("rsp_q");
        respond("rsp_after_q");

        // Reset in the middle of a request drops req at once
        set_op(0, 1'b0, 32'h700, 32'h0);
        tick();
        chk("rst_mid/req_up", dbus.req, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_mid/req_dropped", dbus.req, 1'b0);
        reset = 1'b0;
        clear_op();
        q.delete();
        tick();

        // Randomized loads/stores against the model
        for (int it = 0; it < 60; it++) begin
            idx = $urandom_range(0, 6);
            we  = 1'($urandom_range(0, 1));
            va  = $urandom;
            st  = $urandom;
            if (m_misalign(idx, va)) begin
                set_op(idx, we, va, st);
                settle();
                chk("rnd_ade/ade_l", es_ade_l, !we);
                chk("rnd_ade/ade_s", es_ade_s, we);
                chk("rnd_ade/badvaddr", es_badvaddr, va);
                chk("rnd_ade/rg", es_mem_ready_go, 1'b1);
                tick();
                chk("rnd_ade/no_req", dbus.req, 1'b0);
                clear_op();
            end else begin
                if (q.size() >= 2) respond("rnd_drain");
                dly = $urandom_range(0, 3);
                aw  = 1'($urandom_range(0, 1));
                dok = 1'($urandom_range(0, 1));
                fin = (dly > 0) && ($urandom_range(0, 5) == 0);
                fat = !fin && ($urandom_range(0, 5) == 0);
                issue("rnd", idx, we, va, st, dly, aw, 1, dok, fin, fat);
                if ($urandom_range(0, 1) == 1) respond("rnd_rsp");
            end
        end
        while (q.size() != 0) respond("final_drain");
        respond("final_empty");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
